// File: rtl/pulse_chk_pkg.sv
// pulse_chk_pkg: shared channel state, pulse class codes and the width classifier
package pulse_chk_pkg;
    typedef enum logic {ST_IDLE, ST_MEASURE} state_t;
    typedef enum logic [1:0] {CLS_CLEAN, CLS_REJECT, CLS_ERROR} cls_t;
    // A saturated width means the real pulse was at least that long, so it is always clean
    function automatic cls_t classify(input int unsigned width, input int unsigned w_max,
                                      input int unsigned rej_lim, input int unsigned err_lim);
        return (width >= w_max) ? CLS_CLEAN :
               (width < rej_lim) ? CLS_REJECT :
               (width < err_lim) ? CLS_ERROR : CLS_CLEAN;
    endfunction
endpackage

// File: rtl/pulse_chk_channel.sv
// pulse_chk_channel: per-channel edge detect, level-width counter and classifier
module pulse_chk_channel
    import pulse_chk_pkg::*;
#(
    parameter int W_CNT      = 8,
    parameter int REJECT_LIM = 2,
    parameter int ERROR_LIM  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sig,
    output logic             o_rpt_valid,
    output logic             o_lvl,
    output logic [W_CNT-1:0] o_width,
    output cls_t             o_cls
);
    localparam logic [W_CNT-1:0] W_MAX = '1;
    state_t           r_state, w_state_nxt;
    logic             r_sig_q, r_rpt_valid, r_lvl, w_edge, w_rpt;
    logic [W_CNT-1:0] r_wcnt, w_wcnt_nxt, r_width;
    cls_t             r_cls;
    assign w_edge      = i_sig != r_sig_q;
    assign o_rpt_valid = r_rpt_valid;
    assign o_lvl       = r_lvl;
    assign o_width     = r_width;
    assign o_cls       = r_cls;
    always_ff @(posedge i_clk) begin
        r_sig_q <= i_sig;
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_wcnt      <= '0;
            r_rpt_valid <= 1'b0;
            r_lvl       <= 1'b0;
            r_width     <= '0;
            r_cls       <= CLS_CLEAN;
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_rpt_valid <= w_rpt;
            r_lvl       <= w_rpt & r_sig_q;
            r_width     <= w_rpt ? r_wcnt : '0;
            r_cls       <= w_rpt ? classify(32'(r_wcnt), 32'(W_MAX), REJECT_LIM, ERROR_LIM) : CLS_CLEAN;
        end
    end
    always_comb w_state_nxt = !i_en ? ST_IDLE : w_edge ? ST_MEASURE : r_state;
    // The arming edge starts the count but only edges seen in MEASURE close a pulse
    always_comb begin
        w_rpt      = i_en && r_state == ST_MEASURE && w_edge;
        w_wcnt_nxt = !i_en ? '0 :
                     w_edge ? W_CNT'(1) :
                     (r_state == ST_MEASURE && r_wcnt != W_MAX) ? r_wcnt + 1'b1 : r_wcnt;
    end
endmodule

// File: rtl/pulse_width_checker.sv
// pulse_width_checker: two-channel pulse width monitor with shared report port and event counters
module pulse_width_checker
    import pulse_chk_pkg::*;
#(
    parameter int W_CNT      = 8,
    parameter int REJECT_LIM = 2,
    parameter int ERROR_LIM  = 4,
    parameter int CNT_W      = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [1:0]         i_sig_in,
    input  logic               i_clr_cnt,
    output logic [1:0]         o_reject_stb,
    output logic [1:0]         o_error_stb,
    output logic               o_width_valid,
    output logic               o_width_ch,
    output logic               o_width_lvl,
    output logic [W_CNT-1:0]   o_width_val,
    output logic [2*CNT_W-1:0] o_reject_cnt,
    output logic [2*CNT_W-1:0] o_error_cnt,
    output logic               o_ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [1:0]       w_rv, w_v, w_lvl;
    logic [W_CNT-1:0] w_val [2];
    cls_t             w_cls [2];
    logic             r_pend_v, r_pend_lvl, r_ovf, w_pv;
    logic [W_CNT-1:0] r_pend_val;
    logic [CNT_W-1:0] r_rej [2];
    logic [CNT_W-1:0] r_err [2];
    for (genvar c = 0; c < 2; c++) begin : g_ch
        pulse_chk_channel #(
            .W_CNT(W_CNT), .REJECT_LIM(REJECT_LIM), .ERROR_LIM(ERROR_LIM)
        ) u_ch (
            .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_sig(i_sig_in[c]),
            .o_rpt_valid(w_rv[c]), .o_lvl(w_lvl[c]), .o_width(w_val[c]), .o_cls(w_cls[c])
        );
        assign o_reject_stb[c] = w_v[c] && w_cls[c] == CLS_REJECT;
        assign o_error_stb[c]  = w_v[c] && w_cls[c] == CLS_ERROR;
    end
    assign w_v          = w_rv & {2{i_en}};
    assign w_pv         = r_pend_v & i_en;
    assign o_reject_cnt = {r_rej[1], r_rej[0]};
    assign o_error_cnt  = {r_err[1], r_err[0]};
    assign o_ovf        = r_ovf;
    // Port priority: ch0, then the older pending ch1, then a fresh ch1
    always_comb begin
        o_width_valid = w_v[0] | w_pv | w_v[1];
        o_width_ch    = !w_v[0] && (w_pv || w_v[1]);
        o_width_lvl   = w_v[0] ? w_lvl[0] : w_pv ? r_pend_lvl : w_v[1] && w_lvl[1];
        o_width_val   = w_v[0] ? w_val[0] : w_pv ? r_pend_val : w_v[1] ? w_val[1] : '0;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_en) begin
            r_pend_v   <= 1'b0;
            r_pend_lvl <= 1'b0;
            r_pend_val <= '0;
        end else begin
            r_pend_v <= w_v[0] ? (w_pv | w_v[1]) : (w_pv & w_v[1]);
            if (w_v[1] && (w_v[0] || w_pv)) begin
                r_pend_lvl <= w_lvl[1];
                r_pend_val <= w_val[1];
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr_cnt) begin
            r_rej <= '{default: '0};
            r_err <= '{default: '0};
            r_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (o_reject_stb[i] && r_rej[i] != CNT_MAX) r_rej[i] <= r_rej[i] + 1'b1;
                if (o_error_stb[i] && r_err[i] != CNT_MAX) r_err[i] <= r_err[i] + 1'b1;
            end
            if (w_v[0] && w_v[1] && w_pv) r_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pulse_width_checker.sv
// tb_pulse_width_checker: directed stimulus with a queue scoreboard for reports and strobes
module tb_pulse_width_checker;
    localparam int W = 4;
    localparam int CL = 0, RJ = 1, ER = 2;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, clr_cnt = 1'b0;
    logic [1:0] sig_in = 2'b00;
    logic [1:0] reject_stb, error_stb;
    logic width_valid, width_ch, width_lvl, ovf;
    logic [W-1:0] width_val;
    logic [31:0] reject_cnt, error_cnt;
    int cyc = 0, n_chk = 0, n_err = 0;
    typedef struct {int due; logic ch; logic lvl; logic [W-1:0] val;} rpt_t;
    typedef struct {int due; logic [1:0] rej; logic [1:0] err;} stb_t;
    rpt_t rq[$];
    stb_t sq[$];

    pulse_width_checker #(.W_CNT(W), .REJECT_LIM(2), .ERROR_LIM(4), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sig_in(sig_in), .i_clr_cnt(clr_cnt),
        .o_reject_stb(reject_stb), .o_error_stb(error_stb), .o_width_valid(width_valid),
        .o_width_ch(width_ch), .o_width_lvl(width_lvl), .o_width_val(width_val),
        .o_reject_cnt(reject_cnt), .o_error_cnt(error_cnt), .o_ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expect a completed pulse from the edge driven now: strobe next cycle, report after off cycles (0 = lost)
    task automatic exp(input logic ch, input logic lvl, input int val, input int kind, input int off);
        stb_t s;
        if (off > 0) rq.push_back('{cyc + off, ch, lvl, val[W-1:0]});
        if (kind != CL) begin
            s = '{cyc + 1, 2'b00, 2'b00};
            if (sq.size() > 0 && sq[sq.size()-1].due == cyc + 1) s = sq.pop_back();
            if (kind == RJ) s.rej[ch] = 1'b1;
            else s.err[ch] = 1'b1;
            sq.push_back(s);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_cnt"}, {reject_cnt, error_cnt}, 64'd0);
        chk({name, "_out"}, 64'({reject_stb, error_stb, width_valid, width_ch, width_lvl, width_val, ovf}), 64'd0);
    endtask

    always @(negedge clk) begin : mon
        logic [1:0] er, ee;
        rpt_t e;
        er = 2'b00;
        ee = 2'b00;
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            er |= sq[0].rej;
            ee |= sq[0].err;
            void'(sq.pop_front());
        end
        if (er != 0 || ee != 0 || reject_stb != 0 || error_stb != 0)
            chk("strobes", 64'({reject_stb, error_stb}), 64'({er, ee}));
        if (width_valid) begin
            if (rq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_report cyc=%0d got ch=%0d lvl=%0d val=%0d want none",
                         cyc, width_ch, width_lvl, width_val);
            end else begin
                e = rq.pop_front();
                chk("report", 64'({cyc, width_ch, width_lvl, width_val}), 64'({e.due, e.ch, e.lvl, e.val}));
            end
        end else chk("idle_fields", 64'({width_ch, width_lvl, width_val}), 64'd0);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            sig_in = (i == 0) ? 2'b11 : (i == 1) ? 2'b01 : 2'b00;
            tick(1);
            chk_zero("in_reset");
        end
        rst_n = 1'b1;
        tick(1);
        chk_zero("post_reset1");
        tick(1);
        chk_zero("post_reset2");
        // ch0: arm, 1-cycle high (reject), 2 low (error), 3 high (error), 10 low (clean)
        sig_in = 2'b01; tick(1);
        exp(0, 1, 1, RJ, 1); sig_in = 2'b00; tick(2);
        exp(0, 0, 2, ER, 1); sig_in = 2'b01; tick(3);
        exp(0, 1, 3, ER, 1); sig_in = 2'b00; tick(10);
        chk("cnt_ch0", {reject_cnt, error_cnt}, {16'd0, 16'd1, 16'd0, 16'd2});
        exp(0, 0, 10, CL, 1); sig_in = 2'b01; tick(1);
        sig_in = 2'b11; tick(1);
        exp(0, 1, 2, ER, 1); sig_in = 2'b10; tick(5);
        // simultaneous completion: ch0 width 5 first, ch1 width 6 from the pending slot
        exp(0, 0, 5, CL, 1); exp(1, 1, 6, CL, 2); sig_in = 2'b01; tick(3);
        chk("ovf_simul", 64'(ovf), 64'd0);
        // both toggle every cycle: ch1 reports overwrite the slot, only the last survives
        for (int k = 0; k < 6; k++) begin
            exp(0, k % 2 == 0, (k == 0) ? 3 : 1, (k == 0) ? ER : RJ, 1);
            exp(1, k % 2 != 0, (k == 0) ? 3 : 1, (k == 0) ? ER : RJ, (k == 5) ? 2 : 0);
            sig_in = (k % 2 == 0) ? 2'b10 : 2'b01;
            tick(1);
        end
        tick(2);
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("cnt_toggle", {reject_cnt, error_cnt}, {16'd5, 16'd6, 16'd1, 16'd4});
        tick(17);
        exp(0, 1, 15, CL, 1); sig_in = 2'b00; tick(2);
        chk("ovf_sticky", 64'(ovf), 64'd1);
        clr_cnt = 1'b1; tick(1); clr_cnt = 1'b0; tick(1);
        chk("clr_cnt", {reject_cnt, error_cnt}, 64'd0);
        chk("clr_ovf", 64'(ovf), 64'd0);
        exp(0, 0, 4, CL, 1); sig_in = 2'b01; tick(1);
        exp(0, 1, 1, RJ, 1); sig_in = 2'b00; tick(1);
        clr_cnt = 1'b1; tick(1); clr_cnt = 1'b0;
        chk("clr_wins", 64'(reject_cnt), 64'd0);
        // reset mid-pulse: measurement dropped, next edge only re-arms
        tick(2);
        rst_n = 1'b0; tick(2);
        chk_zero("mid_reset");
        rst_n = 1'b1; tick(2);
        sig_in = 2'b01; tick(3);
        exp(0, 1, 3, ER, 1); sig_in = 2'b00; tick(2);
        // disabled edges are ignored, first edge after enable only arms
        en = 1'b0; sig_in = 2'b01; tick(1);
        sig_in = 2'b00; tick(1);
        en = 1'b1; tick(1);
        sig_in = 2'b01; tick(2);
        exp(0, 1, 2, ER, 1); sig_in = 2'b00; tick(4);
        chk("cnt_final", {reject_cnt, error_cnt}, {16'd0, 16'd0, 16'd0, 16'd2});
        tick(3);
        chk("reports_drained", 64'(rq.size()), 64'd0);
        chk("strobes_drained", 64'(sq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
